i2c_write_master: RTL and testbench

- Single-byte I2C write initiator: generates START, 7-bit address + W bit, ACK slot, one data byte, ACK slot, STOP on scl/sda.
- It is the transmitting counterpart of the team's I2C bus-monitor FSM, which decodes the START condition and the address bits.
- Sits between a host command interface (start/addr/data) and the open-drain I2C pads; reports completion and NACK status.

---
 rtl/i2c_write_master.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_write_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_master.sv
// i2c_write_master: single-byte I2C write initiator.
// Drives START, {addr, W=0}, ACK slot, one data byte, ACK slot, STOP on the
// open-drain pad levels scl/sda_out; reports done/nack to the host.
//
// Ports:
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   start    transfer request, accepted only while idle
//   addr     7-bit target address, latched on accept
//   data     write byte, latched on accept
//   sda_in   sampled SDA bus level (ACK input)
//   scl      SCL level (1 = released)
//   sda_out  SDA drive level (1 = released, 0 = pull low)
//   busy     transfer in progress (through the done cycle)
//   done     one-cycle completion pulse
//   nack     a NACK was seen; valid with done, held until next accept
module i2c_write_master #(
  parameter int unsigned QUARTER = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int unsigned QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state, nxt_state;
  logic [1:0]    phase, nxt_phase;
  logic [QW-1:0] qcnt, nxt_qcnt;
  logic [2:0]    bitcnt, nxt_bitcnt;
  logic          in_data, nxt_in_data;
  logic [7:0]    shreg, nxt_shreg;
  logic [7:0]    dbyte;
  logic          nxt_scl, nxt_sda;
  logic          wrap;

  // Last clock of the current quarter.
  assign wrap = (qcnt == QW'(QUARTER - 1));

  // Next position in the bit-level sequence; outputs are decoded from it so
  // the registered pad levels line up with the state they belong to.
  always_comb begin
    nxt_state   = state;
    nxt_phase   = phase;
    nxt_bitcnt  = bitcnt;
    nxt_in_data = in_data;
    nxt_shreg   = shreg;
    nxt_qcnt    = wrap ? '0 : qcnt + QW'(1);

    case (state)
      S_IDLE: begin
        nxt_qcnt = '0;
        if (start) begin
          nxt_state   = S_START;
          nxt_phase   = 2'd0;
          nxt_bitcnt  = 3'd0;
          nxt_in_data = 1'b0;
          nxt_shreg   = {addr, 1'b0};
        end
      end
      S_START: begin
        if (wrap) begin
          if (phase == 2'd1) begin
            nxt_state = S_BIT;
            nxt_phase = 2'd0;
          end else begin
            nxt_phase = phase + 2'd1;
          end
        end
      end
      S_BIT: begin
        if (wrap) begin
          if (phase == 2'd3) begin
            nxt_phase = 2'd0;
            nxt_shreg = {shreg[6:0], 1'b0};
            if (bitcnt == 3'd7) begin
              nxt_state  = S_ACK;
              nxt_bitcnt = 3'd0;
            end else begin
              nxt_bitcnt = bitcnt + 3'd1;
            end
          end else begin
            nxt_phase = phase + 2'd1;
          end
        end
      end
      S_ACK: begin
        if (wrap) begin
          if (phase == 2'd3) begin
            nxt_phase = 2'd0;
            // nack was sampled at the end of Q2, so it is settled here.
            if (!in_data && !nack) begin
              nxt_state   = S_BIT;
              nxt_in_data = 1'b1;
              nxt_shreg   = dbyte;
            end else begin
              nxt_state = S_STOP;
            end
          end else begin
            nxt_phase = phase + 2'd1;
          end
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (phase == 2'd2) begin
            nxt_state = S_DONE;
            nxt_phase = 2'd0;
          end else begin
            nxt_phase = phase + 2'd1;
          end
        end
      end
      S_DONE: begin
        nxt_qcnt  = '0;
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_qcnt  = '0;
      end
    endcase

    // Pad levels for the upcoming quarter.
    nxt_scl = 1'b1;
    nxt_sda = 1'b1;
    case (nxt_state)
      S_START: begin
        nxt_scl = (nxt_phase == 2'd0);
        nxt_sda = 1'b0;
      end
      S_BIT: begin
        nxt_scl = (nxt_phase == 2'd1) || (nxt_phase == 2'd2);
        nxt_sda = nxt_shreg[7];
      end
      S_ACK: begin
        nxt_scl = (nxt_phase == 2'd1) || (nxt_phase == 2'd2);
        nxt_sda = 1'b1;
      end
      S_STOP: begin
        nxt_scl = (nxt_phase != 2'd0);
        nxt_sda = (nxt_phase == 2'd2);
      end
      default: begin
        nxt_scl = 1'b1;
        nxt_sda = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      phase   <= 2'd0;
      qcnt    <= '0;
      bitcnt  <= 3'd0;
      in_data <= 1'b0;
      shreg   <= 8'd0;
      dbyte   <= 8'd0;
      scl     <= 1'b1;
      sda_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
    end else begin
      state   <= nxt_state;
      phase   <= nxt_phase;
      qcnt    <= nxt_qcnt;
      bitcnt  <= nxt_bitcnt;
      in_data <= nxt_in_data;
      shreg   <= nxt_shreg;
      scl     <= nxt_scl;
      sda_out <= nxt_sda;
      busy    <= (nxt_state != S_IDLE);
      done    <= (nxt_state == S_DONE);
      if (state == S_IDLE && start) begin
        dbyte <= data;
        nack  <= 1'b0;
      end else if (state == S_ACK && phase == 2'd2 && wrap && sda_in) begin
        nack <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: a quarter-level waveform model built from the
// bus rules, a per-cycle compare process, a protocol watcher and directed
// scenarios with literal expectations.
module tb_i2c_write_master;

  localparam int Q = 4;
  localparam int LEN_FULL = 77;
  localparam int LEN_NACK = 41;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] data = 8'h00;
  logic       sda_in = 1'b0;
  logic       scl, sda_out, busy, done, nack;

  i2c_write_master #(.QUARTER(Q)) dut (
    .CLK(CLK), .RST(RST), .start(start), .addr(addr), .data(data),
    .sda_in(sda_in), .scl(scl), .sda_out(sda_out), .busy(busy),
    .done(done), .nack(nack)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int         cyc = 0;
  int         pos = -1;     // cycles into current transfer, -1 = idle
  int         len = 0;      // quarters in current transfer
  int         acc_cyc = 0;
  logic       m_nack = 1'b0;
  logic       after_rst = 1'b0;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic [1:0] wave [0:LEN_FULL-1];  // {scl, sda} per quarter
  int         wq;
  logic       cfg_addr_nack = 1'b0;
  logic       cfg_data_nack = 1'b0;

  task automatic put(input logic s, input logic d);
    wave[wq] = {s, d};
    wq++;
  endtask

  task automatic put_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      put(1'b0, b[i]); put(1'b1, b[i]); put(1'b1, b[i]); put(1'b0, b[i]);
    end
    put(1'b0, 1'b1); put(1'b1, 1'b1); put(1'b1, 1'b1); put(1'b0, 1'b1);
  endtask

  task automatic build(input logic addr_nacked);
    wq = 0;
    put(1'b1, 1'b0); put(1'b0, 1'b0);
    put_byte({m_addr, 1'b0});
    if (!addr_nacked) put_byte(m_data);
    put(1'b0, 1'b0); put(1'b1, 1'b0); put(1'b1, 1'b1);
    len = wq;
  endtask

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      pos = -1;
      m_nack = 1'b0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (pos < 0) begin
        if (start) begin
          m_addr = addr;
          m_data = data;
          m_nack = 1'b0;
          build(1'b0);
          pos = 0;
          acc_cyc = cyc;
        end
      end else if (pos == len * Q) begin
        pos = -1;
      end else begin
        if (pos == 36 * Q + Q - 1 && sda_in) begin
          m_nack = 1'b1;
          build(1'b1);
        end
        if (len == LEN_FULL && pos == 72 * Q + Q - 1 && sda_in) m_nack = 1'b1;
        pos++;
      end
    end
  end

  // Slave ACK drive: address-slot level until quarter 38, data-slot after.
  always @(negedge CLK)
    sda_in = (pos >= 38 * Q) ? cfg_data_nack : cfg_addr_nack;

  // ---------------- compare / protocol ----------------
  logic        chk_en = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [31:0] rbits = '0;
  int          rcount = 0;

  always @(negedge CLK) begin
    logic e_scl, e_sda, e_busy, e_done;
    if (chk_en) begin
      if (pos < 0) begin
        e_scl = 1'b1; e_sda = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else if (pos < len * Q) begin
        e_scl = wave[pos / Q][1]; e_sda = wave[pos / Q][0];
        e_busy = 1'b1; e_done = 1'b0;
      end else begin
        e_scl = 1'b1; e_sda = 1'b1; e_busy = 1'b1; e_done = 1'b1;
      end
      chk("scl", scl, e_scl);
      chk("sda_out", sda_out, e_sda);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("nack", nack, m_nack);

      if (!after_rst && prev_scl && scl) begin
        n_chk++;
        if (sda_out !== prev_sda &&
            !((prev_sda && !sda_out && pos == 0) ||
              (!prev_sda && sda_out && pos >= 0 && pos == (len - 1) * Q))) begin
          n_err++;
          $display("FAIL protocol t=%0t sda %b->%b while scl high, pos=%0d",
                   $time, prev_sda, sda_out, pos);
        end
      end
      if (!prev_scl && scl) begin
        rbits = {rbits[30:0], sda_out};
        rcount++;
      end
      prev_scl = scl;
      prev_sda = sda_out;
    end
  end

  // ---------------- scenarios ----------------
  task automatic wait_done(input int maxc, output int lat);
    logic found;
    found = 1'b0;
    lat = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        found = 1'b1;
        lat = cyc - acc_cyc;
        break;
      end
    end
    if (!found) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout t=%0t actual=none expected=done within %0d", $time, maxc);
    end
  endtask

  task automatic launch(input logic [6:0] a, input logic [7:0] d);
    addr = a;
    data = d;
    rbits = '0;
    rcount = 0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    addr = 7'h7F;   // later changes must not affect the transfer in flight
    data = 8'h00;
  endtask

  int lat;

  initial begin
    // 1: reset with start held high
    RST = 1'b1;
    start = 1'b1;
    addr = 7'h50;
    data = 8'hA5;
    @(negedge CLK);
    chk_en = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    start = 1'b0;
    @(negedge CLK);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nack", nack, 1'b0);
    repeat (3) @(negedge CLK);
    chk("rst_idle_busy", busy, 1'b0);

    // 2: ACKed transfer 0x50 / 0xA5
    cfg_addr_nack = 1'b0;
    cfg_data_nack = 1'b0;
    launch(7'h50, 8'hA5);
    chk("accept_busy", busy, 1'b1);
    wait_done(400, lat);
    chk_int("ack_latency", lat, 308);
    chk_int("ack_rise_count", rcount, 19);
    chk_int("ack_rise_bits", int'(rbits[18:0]), int'(19'b1010000_0_1_10100101_1_0));
    chk("ack_nack", nack, 1'b0);
    repeat (2) @(negedge CLK);

    // 3: address NACK
    cfg_addr_nack = 1'b1;
    cfg_data_nack = 1'b1;
    launch(7'h50, 8'hA5);
    wait_done(400, lat);
    chk_int("anack_latency", lat, 164);
    chk_int("anack_rise_count", rcount, 10);
    chk_int("anack_rise_bits", int'(rbits[9:0]), int'(10'b1010000_0_1_0));
    chk("anack_nack", nack, 1'b1);
    repeat (5) @(negedge CLK);
    chk("anack_nack_held", nack, 1'b1);

    // 4: data NACK only
    cfg_addr_nack = 1'b0;
    cfg_data_nack = 1'b1;
    launch(7'h3C, 8'h5A);
    chk("dnack_cleared", nack, 1'b0);
    wait_done(400, lat);
    chk_int("dnack_latency", lat, 308);
    chk("dnack_nack", nack, 1'b1);
    repeat (2) @(negedge CLK);

    // 5: start held through busy and DONE, then back-to-back
    cfg_addr_nack = 1'b0;
    cfg_data_nack = 1'b0;
    addr = 7'h2A;
    data = 8'h3C;
    start = 1'b1;
    wait_done(400, lat);
    chk_int("b2b_first_latency", lat, 308);
    @(negedge CLK);
    chk("b2b_idle_gap", busy, 1'b0);
    @(negedge CLK);
    chk("b2b_second_busy", busy, 1'b1);
    start = 1'b0;
    wait_done(400, lat);
    chk_int("b2b_second_latency", lat, 308);
    chk("b2b_nack", nack, 1'b0);
    repeat (2) @(negedge CLK);

    // 6: reset during address bit 3 high phase
    launch(7'h50, 8'hA5);
    for (int i = 0; i < 200; i++) begin
      if (pos == 15 * Q) break;
      @(negedge CLK);
    end
    chk("abort_scl_high", scl, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_scl", scl, 1'b1);
    chk("abort_sda", sda_out, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(negedge CLK);
    launch(7'h50, 8'hA5);
    wait_done(400, lat);
    chk_int("abort_relaunch_latency", lat, 308);
    chk_int("abort_relaunch_bits", int'(rbits[18:0]), int'(19'b1010000_0_1_10100101_1_0));
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
